// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and types: PC width, reset/exception vectors,
// fetch-stage FSM encoding and a word-alignment helper.
package cpu_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] RESET_PC   = 32'h0040_0000;
    localparam logic [PC_W-1:0] EXC_VECTOR = 32'h8000_0004;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } if_state_e;

    // Instruction addresses are word aligned; the low two bits are forced to zero.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/npc_sel.sv
// Combinational next-PC redirect selector: exc_req > jr > branch_taken > jump.
// The exception source exists only when EXCEPTION_EN is defined.
module npc_sel
    import cpu_pkg::*;
(
`ifdef EXCEPTION_EN
    input  logic            exc_req_i,
`endif
    input  logic            jr_i,
    input  logic [PC_W-1:0] jr_target_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_target_i,
    output logic            redir_o,
    output logic [PC_W-1:0] redir_target_o
`ifdef EXCEPTION_EN
    ,
    output logic            redir_exc_o
`endif
);

    logic [PC_W-1:0] sel_target;

    always_comb begin
        redir_o    = 1'b1;
        sel_target = '0;
`ifdef EXCEPTION_EN
        redir_exc_o = 1'b0;
        if (exc_req_i) begin
            sel_target  = EXC_VECTOR;
            redir_exc_o = 1'b1;
        end else
`endif
        if (jr_i) begin
            sel_target = jr_target_i;
        end else if (branch_taken_i) begin
            sel_target = branch_target_i;
        end else if (jump_i) begin
            sel_target = jump_target_i;
        end else begin
            redir_o = 1'b0;
        end
        redir_target_o = align_pc(sel_target);
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch PC register with a RUN/PEND FSM that parks redirects while hold
// is high. Define EXCEPTION_EN to add exc_req, epc and the exception vector redirect.
module if_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
`ifdef EXCEPTION_EN
    input  logic            exc_req,
`endif
    output logic [PC_W-1:0] PC_IF,
    output logic [PC_W-1:0] PC_plus4,
    output logic            flush_IFID,
    output logic            redirect_pending
`ifdef EXCEPTION_EN
    ,
    output logic [PC_W-1:0] epc
`endif
);

    if_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic            redir;
    logic [PC_W-1:0] redir_target;
`ifdef EXCEPTION_EN
    logic            sel_exc;
    logic            pend_exc_q, pend_exc_d;
    logic [PC_W-1:0] epc_q, epc_d;
`endif

    npc_sel u_npc_sel (
`ifdef EXCEPTION_EN
        .exc_req_i       (exc_req),
        .redir_exc_o     (sel_exc),
`endif
        .jr_i            (jr),
        .jr_target_i     (jr_target),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .redir_o         (redir),
        .redir_target_o  (redir_target)
    );

    assign PC_IF    = pc_q;
    assign PC_plus4 = pc_q + PC_W'(4);

    // Gated by reset so the squash stays quiet while the stage is held in reset.
    assign flush_IFID       = reset && !hold && (redir || (state_q == PEND));
    assign redirect_pending = (state_q == PEND);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
`ifdef EXCEPTION_EN
        pend_exc_d = pend_exc_q;
        epc_d      = sel_exc ? pc_q : epc_q;
`endif
        case (state_q)
            RUN: begin
                if (!hold) begin
                    pc_d = redir ? redir_target : PC_plus4;
                end else if (redir) begin
                    state_d   = PEND;
                    pend_pc_d = redir_target;
`ifdef EXCEPTION_EN
                    pend_exc_d = sel_exc;
`endif
                end
            end
            PEND: begin
                if (!hold) begin
                    pc_d    = pend_pc_q;
                    state_d = RUN;
`ifdef EXCEPTION_EN
                    if (sel_exc) pc_d = EXC_VECTOR;
                    pend_exc_d = 1'b0;
`endif
                end else if (redir) begin
`ifdef EXCEPTION_EN
                    // A parked exception may only be replaced by another exception.
                    if (!pend_exc_q || sel_exc) begin
                        pend_pc_d  = redir_target;
                        pend_exc_d = sel_exc;
                    end
`else
                    pend_pc_d = redir_target;
`endif
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
`ifdef EXCEPTION_EN
            pend_exc_q <= 1'b0;
            epc_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
`ifdef EXCEPTION_EN
            pend_exc_q <= pend_exc_d;
            epc_q      <= epc_d;
`endif
        end
    end

`ifdef EXCEPTION_EN
    assign epc = epc_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares. EXCEPTION_EN adds the exception scenarios.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hold = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic [31:0] PC_IF;
    logic [31:0] PC_plus4;
    logic        flush_IFID;
    logic        redirect_pending;
`ifdef EXCEPTION_EN
    logic        exc_req = 1'b0;
    logic [31:0] epc;
`endif

    if_stage dut (
        .clk              (clk),
        .reset            (reset),
        .hold             (hold),
        .jump             (jump),
        .jump_target      (jump_target),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jr               (jr),
        .jr_target        (jr_target),
`ifdef EXCEPTION_EN
        .exc_req          (exc_req),
        .epc              (epc),
`endif
        .PC_IF            (PC_IF),
        .PC_plus4         (PC_plus4),
        .flush_IFID       (flush_IFID),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic        fl;
        logic        pd;
        logic        ce;
        logic [31:0] ep;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", nm, act, req);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, req);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked at the falling edge.
    task automatic cyc(input logic rs, input logic h,
                       input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt,
                       input logic r, input logic [31:0] rt,
                       input logic ex, input string nm,
                       input logic [31:0] pc, input logic fl, input logic pd,
                       input logic ce = 1'b0, input logic [31:0] ep = 32'h0);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rs; hold = h;
        jump = j; jump_target = jt;
        branch_taken = b; branch_target = bt;
        jr = r; jr_target = rt;
`ifdef EXCEPTION_EN
        exc_req = ex;
`else
        if (ex) $display("note: %s exception stimulus ignored in this build", nm);
`endif
        e.nm = nm; e.pc = pc; e.fl = fl; e.pd = pd; e.ce = ce; e.ep = ep;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            $display("txn %-12s PC_IF=%08h PC_plus4=%08h flush=%b pend=%b",
                     e.nm, PC_IF, PC_plus4, flush_IFID, redirect_pending);
            chk32({e.nm, ".pc"},    PC_IF,            e.pc);
            chk32({e.nm, ".pc4"},   PC_plus4,         e.pc + 32'd4);
            chk1 ({e.nm, ".flush"}, flush_IFID,       e.fl);
            chk1 ({e.nm, ".pend"},  redirect_pending, e.pd);
`ifdef EXCEPTION_EN
            if (e.ce) chk32({e.nm, ".epc"}, epc, e.ep);
`endif
        end
    end

    localparam logic [31:0] Z = 32'h0;

    initial begin
        //  rs h  j  jt            b  bt            r  rt            ex name        pc            fl pd
        cyc(0, 0, 0, Z,            1, 32'h00001000, 0, Z,            0, "in_reset",  32'h00400000, 0, 0);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "rel0",      32'h00400000, 0, 0);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "rel1",      32'h00400004, 0, 0);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "rel2",      32'h00400008, 0, 0);
        cyc(1, 0, 0, Z,            1, 32'h00400102, 0, Z,            0, "br_req",    32'h0040000C, 1, 0);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "br_tgt",    32'h00400100, 0, 0);
        cyc(1, 0, 1, 32'h00400200, 0, Z,            1, 32'h00400300, 0, "jjr_req",   32'h00400104, 1, 0);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "jjr_tgt",   32'h00400300, 0, 0);
        cyc(1, 1, 0, Z,            1, 32'h00400400, 0, Z,            0, "hold0",     32'h00400304, 0, 0);
        cyc(1, 1, 0, Z,            0, Z,            0, Z,            0, "hold1",     32'h00400304, 0, 1);
        cyc(1, 1, 0, Z,            0, Z,            0, Z,            0, "hold2",     32'h00400304, 0, 1);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "hold_rel",  32'h00400304, 1, 1);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "hold_tgt",  32'h00400400, 0, 0);
        cyc(1, 1, 1, 32'h00400500, 0, Z,            0, Z,            0, "ovw0",      32'h00400404, 0, 0);
        cyc(1, 1, 0, Z,            0, Z,            1, 32'h00400603, 0, "ovw1",      32'h00400404, 0, 1);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "ovw_rel",   32'h00400404, 1, 1);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "ovw_tgt",   32'h00400600, 0, 0);
        cyc(1, 0, 1, 32'hFFFFFFFF, 0, Z,            0, Z,            0, "top_req",   32'h00400604, 1, 0);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "top_pc",    32'hFFFFFFFC, 0, 0);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "wrap",      32'h00000000, 0, 0);
        cyc(1, 1, 0, Z,            1, 32'h00001000, 0, Z,            0, "prst0",     32'h00000004, 0, 0);
        cyc(1, 1, 0, Z,            0, Z,            0, Z,            0, "prst1",     32'h00000004, 0, 1);
        cyc(0, 1, 0, Z,            0, Z,            0, Z,            0, "prst_rst",  32'h00400000, 0, 0);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "prst_rel",  32'h00400000, 0, 0);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "prst_seq",  32'h00400004, 0, 0);
`ifdef EXCEPTION_EN
        cyc(1, 1, 0, Z,            0, Z,            0, Z,            1, "exc0",      32'h00400008, 0, 0);
        cyc(1, 1, 1, 32'h00400700, 0, Z,            0, Z,            0, "exc_jmp",   32'h00400008, 0, 1);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "exc_rel",   32'h00400008, 1, 1);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "exc_tgt",   32'h80000004, 0, 0, 1, 32'h00400008);
        cyc(1, 0, 0, Z,            0, Z,            1, 32'h00400800, 1, "exc_jr",    32'h80000008, 1, 0);
        cyc(1, 0, 0, Z,            0, Z,            0, Z,            0, "exc_jr_t",  32'h80000004, 0, 0, 1, 32'h80000008);
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 pending expectations", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port hold, input, 1, stall from hazard unit, the same signal that freezes IF_ID.
REQ-004 SHALL have port jump / jump_target, input, 1 / 32, J/JAL redirect request and target.
REQ-005 SHALL have port branch_taken / branch_target, input, 1 / 32, resolved-taken branch and its target.
REQ-006 SHALL have port jr / jr_target, input, 1 / 32, JR/JALR redirect request and register target.
REQ-007 SHALL have port exc_req, input, 1, exception/interrupt request (present only under EXCEPTION_EN).
REQ-008 SHALL have port PC_IF, output, 32, current fetch address to instruction memory and IF_ID.
REQ-009 SHALL have port PC_plus4, output, 32, PC_IF + 4, for link-register writeback.
REQ-010 SHALL have port flush_IFID, output, 1, squash request to IF_ID.
REQ-011 SHALL have port redirect_pending, output, 1, high while a redirect is latched and waiting for hold release.
REQ-012 SHALL have port epc, output, 32, PC_IF captured on exception acceptance (present only under EXCEPTION_EN).

Function
REQ-013 SHALL, per cycle, select the redirect source by priority: exc_req > jr > branch_taken > jump; otherwise sequential.
REQ-014 SHALL force bits [1:0] of every selected target to 0.
REQ-015 SHALL compute PC_plus4 combinationally, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
REQ-016 SHALL use two FSM states: RUN and PEND.
REQ-017 SHALL in RUN with hold=0: load PC_IF with the selected redirect target if any, else PC_plus4, on the next edge.
REQ-018 SHALL in RUN with hold=1 and a redirect present: keep PC_IF, latch the target into pend_pc (and pend_exc for exceptions), and move to PEND.
REQ-019 SHALL in RUN with hold=1 and no redirect: keep PC_IF and stay in RUN.
REQ-020 SHALL in PEND with hold=1: keep PC_IF, and overwrite pend_pc with any new redirect unless pend_exc=1 and the new request is not exc_req.
REQ-021 SHALL in PEND with hold=0: load PC_IF from the highest of a same-cycle exc_req or pend_pc, clear pend_exc, and return to RUN.
REQ-022 SHALL assert flush_IFID combinationally whenever hold=0 and either a redirect is present or the state is PEND; it is otherwise 0.
REQ-023 SHALL drive redirect_pending = (state == PEND).
REQ-024 SHALL give redirects a latency of one edge after hold=0: the target appears on PC_IF the following cycle.

Reset
REQ-025 SHALL while reset=0 asynchronously set PC_IF=RESET_PC (0x00400000), state=RUN, pend_pc=0, pend_exc=0, epc=0.
REQ-026 SHALL, as a consequence of REQ-025, hold flush_IFID=0, redirect_pending=0 and PC_plus4=0x00400004 during reset.
REQ-027 SHALL discard any pending redirect when reset asserts mid-operation.
REQ-028 SHALL make the first fetch after reset release RESET_PC.

Configuration
REQ-029 SHALL, with EXCEPTION_EN defined, include exc_req and epc, redirect to EXC_VECTOR (0x80000004), and load epc with PC_IF when the exception is accepted.
REQ-030 SHALL, with EXCEPTION_EN undefined, omit exc_req, epc and pend_exc, leaving priority jr > branch_taken > jump.

Structure
REQ-031 SHALL take RESET_PC, EXC_VECTOR, the 2-state FSM enum and the PC width from shared package cpu_pkg.
REQ-032 SHALL place next-PC priority selection in one combinational sub-module, npc_sel; the PC register and FSM stay in if_stage.

Verification
REQ-033 SHALL cover: reset release with hold=0 for 3 cycles -> PC_IF = 0x00400000, 0x00400004, 0x00400008; flush_IFID=0.
REQ-034 SHALL cover: branch_taken=1, target=0x00400102, hold=0 -> flush_IFID=1 that cycle, next PC_IF=0x00400100.
REQ-035 SHALL cover: jump and jr in the same cycle (targets 0x00400200 / 0x00400300) -> next PC_IF=0x00400300.
REQ-036 SHALL cover: branch to 0x00400400 with hold=1 for 3 cycles -> redirect_pending=1 and PC_IF frozen; at hold release flush_IFID=1, then PC_IF=0x00400400.
REQ-037 SHALL cover: under EXCEPTION_EN, exc_req during PEND then jump while hold=1 -> after release PC_IF=0x80000004 and epc=the frozen PC_IF.
REQ-038 SHALL cover: PC_IF=0xFFFFFFFC, hold=0 -> next PC_IF=0x00000000; and reset=0 while PEND -> PC_IF=0x00400000, redirect_pending=0.
